// File: rtl/riscv_pkg.sv
// Shared constants for the pipelined_riscv core.
package riscv_pkg;

    localparam int XLEN = 32;
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
    // addi x0, x0, 0: the canonical RISC-V no-op
    localparam logic [31:0] NOP = 32'h0000_0013;

endpackage

// File: rtl/fetch_buf.sv
// Small synchronous FIFO with flush, used as the in-order tag queue and the
// fetched-instruction buffer. DEPTH must be a power of two (>= 2).
module fetch_buf #(
    parameter int W     = 32,
    parameter int DEPTH = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  logic                   pop,
    input  logic                   flush,
    input  logic [W-1:0]           din,
    output logic [W-1:0]           dout,
    output logic [$clog2(DEPTH):0] count,
    output logic                   full,
    output logic                   empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [AW-1:0] PTR_ONE  = AW'(1'b1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1'b1);
    localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);

    logic [W-1:0]  mem_r [DEPTH];
    logic [AW-1:0] wptr_r;
    logic [AW-1:0] rptr_r;
    logic [CW-1:0] count_r;
    logic          wr_en_s;
    logic          rd_en_s;

    // A push into a full FIFO is accepted only when a pop frees a slot the same cycle.
    assign wr_en_s = push && ((count_r != CNT_FULL) || pop);
    assign rd_en_s = pop && (count_r != {CW{1'b0}});

    assign dout  = mem_r[rptr_r];
    assign count = count_r;
    assign full  = (count_r == CNT_FULL);
    assign empty = (count_r == {CW{1'b0}});

    // Pointer and occupancy bookkeeping; flush discards all entries.
    always_ff @(posedge clk) begin
        if (!rst || flush) begin
            wptr_r  <= {AW{1'b0}};
            rptr_r  <= {AW{1'b0}};
            count_r <= {CW{1'b0}};
        end else begin
            if (wr_en_s) wptr_r <= wptr_r + PTR_ONE;
            if (rd_en_s) rptr_r <= rptr_r + PTR_ONE;
            case ({wr_en_s, rd_en_s})
                2'b10:   count_r <= count_r + CNT_ONE;
                2'b01:   count_r <= count_r - CNT_ONE;
                default: count_r <= count_r;
            endcase
        end
    end

    // Storage array write port (contents need no reset).
    always_ff @(posedge clk) begin
        if (wr_en_s && rst && !flush) mem_r[wptr_r] <= din;
    end

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: PC, imem req/gnt/rvalid handshake, epoch-tagged
// in-order response tracking, response buffer and the IF/ID register.
module fetch_stage #(
    parameter int               XLEN      = riscv_pkg::XLEN,
    parameter logic [XLEN-1:0]  RESET_PC  = riscv_pkg::RESET_PC_DEFAULT,
    parameter int               MAX_OUTST = 2
) (
    input  logic            clk,
    input  logic            rst,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_gnt,
    input  logic            imem_rvalid,
    input  logic [XLEN-1:0] imem_rdata,
    input  logic            id_stall,
    input  logic            ex_redirect,
    input  logic [XLEN-1:0] ex_target,
    output logic            if_id_valid,
    output logic [XLEN-1:0] if_id_pc,
    output logic [XLEN-1:0] if_id_pc4,
    output logic [XLEN-1:0] if_id_instr
);
    import riscv_pkg::*;

    localparam int CW = $clog2(MAX_OUTST) + 1;
    localparam logic [XLEN-1:0] PC_STEP     = XLEN'(3'd4);
    localparam logic [XLEN-1:0] PC_MASK     = ~XLEN'(2'd3);
    localparam logic [XLEN-1:0] ZERO_W      = {XLEN{1'b0}};
    localparam logic [XLEN-1:0] NOP_W       = XLEN'(NOP);
    localparam logic [CW:0]     OUTST_LIMIT = (CW + 1)'(MAX_OUTST);

    logic [XLEN-1:0]   pc_r;
    logic              epoch_r;
    logic              if_id_valid_r;
    logic [XLEN-1:0]   if_id_pc_r;
    logic [XLEN-1:0]   if_id_pc4_r;
    logic [XLEN-1:0]   if_id_instr_r;

    logic [XLEN:0]     tq_din_s;
    logic [XLEN:0]     tq_dout_s;
    logic [CW-1:0]     tq_count_s;
    logic              tq_full_s;
    logic              tq_empty_s;
    logic              tq_push_s;
    logic              tq_pop_s;

    logic [2*XLEN-1:0] rb_din_s;
    logic [2*XLEN-1:0] rb_dout_s;
    logic [CW-1:0]     rb_count_s;
    logic              rb_full_s;
    logic              rb_empty_s;
    logic              rb_push_s;
    logic              rb_pop_s;

    logic [CW:0]       inflight_s;
    logic              req_s;
    logic              tag_epoch_s;
    logic [XLEN-1:0]   tag_pc_s;
    logic              keep_s;
    logic              load_s;
    logic              nxt_valid_s;
    logic [XLEN-1:0]   nxt_pc_s;
    logic [XLEN-1:0]   nxt_instr_s;

    // In-flight requests plus buffered responses never exceed MAX_OUTST, so
    // every granted request is guaranteed a buffer slot when it returns.
    assign inflight_s = {1'b0, tq_count_s} + {1'b0, rb_count_s};
    assign req_s      = rst && !ex_redirect && (inflight_s < OUTST_LIMIT)
                        && !tq_full_s && !rb_full_s;
    assign imem_req   = req_s;
    assign imem_addr  = pc_r;

    // Each request carries its epoch and PC through the tag queue.
    assign tq_push_s   = req_s && imem_gnt;
    assign tq_pop_s    = imem_rvalid && !tq_empty_s;
    assign tq_din_s    = {epoch_r, pc_r};
    assign tag_epoch_s = tq_dout_s[XLEN];
    assign tag_pc_s    = tq_dout_s[XLEN-1:0];

    // A response is useful only if it belongs to the current epoch and no redirect is killing it now.
    assign keep_s   = imem_rvalid && !tq_empty_s && (tag_epoch_s == epoch_r) && !ex_redirect;
    assign rb_din_s = {tag_pc_s, imem_rdata};
    assign load_s   = !id_stall || !if_id_valid_r;

    fetch_buf #(.W(XLEN + 1), .DEPTH(MAX_OUTST)) u_tag_q (
        .clk   (clk),
        .rst   (rst),
        .push  (tq_push_s),
        .pop   (tq_pop_s),
        .flush (1'b0),
        .din   (tq_din_s),
        .dout  (tq_dout_s),
        .count (tq_count_s),
        .full  (tq_full_s),
        .empty (tq_empty_s)
    );

    fetch_buf #(.W(2 * XLEN), .DEPTH(MAX_OUTST)) u_resp_buf (
        .clk   (clk),
        .rst   (rst),
        .push  (rb_push_s),
        .pop   (rb_pop_s),
        .flush (ex_redirect),
        .din   (rb_din_s),
        .dout  (rb_dout_s),
        .count (rb_count_s),
        .full  (rb_full_s),
        .empty (rb_empty_s)
    );

    // Select the next IF/ID contents: redirect bubble, buffer head, bypassed response, bubble, or hold.
    always_comb begin
        nxt_valid_s = if_id_valid_r;
        nxt_pc_s    = if_id_pc_r;
        nxt_instr_s = if_id_instr_r;
        rb_push_s   = 1'b0;
        rb_pop_s    = 1'b0;
        if (ex_redirect) begin
            nxt_valid_s = 1'b0;
            nxt_pc_s    = ZERO_W;
            nxt_instr_s = NOP_W;
        end else if (load_s) begin
            if (!rb_empty_s) begin
                nxt_valid_s = 1'b1;
                nxt_pc_s    = rb_dout_s[2*XLEN-1:XLEN];
                nxt_instr_s = rb_dout_s[XLEN-1:0];
                rb_pop_s    = 1'b1;
                rb_push_s   = keep_s;
            end else if (keep_s) begin
                nxt_valid_s = 1'b1;
                nxt_pc_s    = tag_pc_s;
                nxt_instr_s = imem_rdata;
            end else begin
                nxt_valid_s = 1'b0;
                nxt_pc_s    = ZERO_W;
                nxt_instr_s = NOP_W;
            end
        end else begin
            rb_push_s = keep_s;
        end
    end

    // PC advances on grant; redirect reloads it and starts a new epoch.
    always_ff @(posedge clk) begin
        if (!rst) begin
            pc_r    <= RESET_PC;
            epoch_r <= 1'b0;
        end else if (ex_redirect) begin
            pc_r    <= ex_target & PC_MASK;
            epoch_r <= ~epoch_r;
        end else if (tq_push_s) begin
            pc_r    <= pc_r + PC_STEP;
        end
    end

    // IF/ID pipeline register.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if_id_valid_r <= 1'b0;
            if_id_pc_r    <= ZERO_W;
            if_id_pc4_r   <= ZERO_W;
            if_id_instr_r <= NOP_W;
        end else begin
            if_id_valid_r <= nxt_valid_s;
            if_id_pc_r    <= nxt_pc_s;
            if_id_pc4_r   <= nxt_valid_s ? (nxt_pc_s + PC_STEP) : ZERO_W;
            if_id_instr_r <= nxt_instr_s;
        end
    end

    assign if_id_valid = if_id_valid_r;
    assign if_id_pc    = if_id_pc_r;
    assign if_id_pc4   = if_id_pc4_r;
    assign if_id_instr = if_id_instr_r;

endmodule
